// File: rtl/nmr_pck_pkg.sv
// Shared types and constants for the NMR sample packer.
// Optional build macro: NMR_PCK_TIMESTAMP_EN (see nmr_sample_packer.sv).
package nmr_pck_pkg;

  // Packer life cycle: one acquisition window per reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pck_state_e;

  // Upper word of the optional header beat, lets the DMA consumer find it.
  localparam logic [31:0] HDR_MAGIC = 32'hA5A5_0001;

  // Boxcar accumulator must hold 2^max_log2 full-scale samples without wrap.
  function automatic int acc_width(input int data_w, input int max_log2);
    return data_w + max_log2;
  endfunction

endpackage

// File: rtl/nmr_pck_fifo.sv
// Synchronous output FIFO for packed beats.
// A push while full is accepted only when a pop happens on the same edge;
// otherwise the beat is dropped and 'drop' pulses for that cycle.
// pop_data reads as zero while empty so the stream outputs are clean in reset.
module nmr_pck_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; when full with a pop the write lands on the slot being freed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/nmr_sample_packer.sv
// NMR acquisition sample packer: boxcar-decimates the dual-channel ADC
// stream, packs two decimated pairs per beat and streams them out with
// burst tlast markers, stopping after cfg_nb_of_sample decimated samples.
// Optional build macro NMR_PCK_TIMESTAMP_EN: prepend a {HDR_MAGIC, cycle
// count} header beat at the start of RUN.
//
// Output stream handshake: a beat transfers on any clock edge where
// m_axis_tvalid and m_axis_tready are both high; while tvalid is high and
// tready low, tdata/tlast hold their value. The ADC input has no ready and
// is sampled on every edge where s_adc_tvalid is high.
module nmr_sample_packer
  import nmr_pck_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int MAX_DECIM_LOG2 = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   s_adc_tdata,
  input  logic                  s_adc_tvalid,
  input  logic [31:0]           cfg_nb_of_sample,
  input  logic [31:0]           cfg_size,
  input  logic [3:0]            cfg_decim_log2,
  output logic [4*DATA_W-1:0]   m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           sample_cnt
);

  localparam int ACC_W  = acc_width(DATA_W, MAX_DECIM_LOG2);
  localparam int PAIR_W = 2 * DATA_W;
  localparam int BEAT_W = 4 * DATA_W;
  localparam int CNT_W  = MAX_DECIM_LOG2 + 1;

  pck_state_e state_q;
  pck_state_e state_d;

  // Latched configuration
  logic [31:0] nb_q;
  logic [31:0] size_q;
  logic [3:0]  dlog_q;
  logic [3:0]  dlog_clamped;

  // Decimator
  logic signed [ACC_W-1:0] acc_a_q;
  logic signed [ACC_W-1:0] acc_b_q;
  logic signed [ACC_W-1:0] sum_a;
  logic signed [ACC_W-1:0] sum_b;
  logic [DATA_W-1:0]       dec_a;
  logic [DATA_W-1:0]       dec_b;
  logic [CNT_W-1:0]        dcnt_q;
  logic [CNT_W-1:0]        dec_last_idx;
  logic                    sample_take;
  logic                    dec_fire;
  logic                    dec_valid_q;
  logic                    dec_last_q;
  logic [PAIR_W-1:0]       dec_pair_q;
  logic [31:0]             sample_cnt_q;

  // Packer and burst tracking
  logic [PAIR_W-1:0] low_q;
  logic              have_low_q;
  logic [31:0]       burst_cnt_q;
  logic              burst_wrap;
  logic              push_en;
  logic [BEAT_W-1:0] push_data;
  logic              push_last;
  logic              overflow_q;

  // FIFO side
  logic [BEAT_W:0] fifo_out;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_drop;

`ifdef NMR_PCK_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic        hdr_pending_q;
`endif

  assign dlog_clamped = (cfg_decim_log2 > 4'(MAX_DECIM_LOG2)) ? 4'(MAX_DECIM_LOG2)
                                                              : cfg_decim_log2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one acquisition per reset, DONE holds until the next reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = (cfg_nb_of_sample == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (sample_cnt_q == nb_q) state_d = ST_FLUSH;
      ST_FLUSH: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Configuration is captured only in the single IDLE cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nb_q   <= '0;
      size_q <= '0;
      dlog_q <= '0;
    end else if (state_q == ST_IDLE) begin
      nb_q   <= cfg_nb_of_sample;
      size_q <= cfg_size;
      dlog_q <= dlog_clamped;
    end
  end

  // Samples are taken only in RUN and only until the target count is met.
  assign sample_take  = (state_q == ST_RUN) && s_adc_tvalid && (sample_cnt_q != nb_q);
  assign dec_last_idx = (CNT_W'(1) << dlog_q) - CNT_W'(1);
  assign dec_fire     = sample_take && (dcnt_q == dec_last_idx);
  assign sum_a        = acc_a_q + ACC_W'(signed'(s_adc_tdata[DATA_W-1:0]));
  assign sum_b        = acc_b_q + ACC_W'(signed'(s_adc_tdata[PAIR_W-1:DATA_W]));
  assign dec_a        = DATA_W'(sum_a >>> dlog_q);
  assign dec_b        = DATA_W'(sum_b >>> dlog_q);

  // Boxcar accumulate; the block average is registered so d=0 is a 1-cycle pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      dcnt_q       <= '0;
      dec_valid_q  <= 1'b0;
      dec_last_q   <= 1'b0;
      dec_pair_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      dec_valid_q <= 1'b0;
      dec_last_q  <= 1'b0;
      if (dec_fire) begin
        acc_a_q      <= '0;
        acc_b_q      <= '0;
        dcnt_q       <= '0;
        dec_valid_q  <= 1'b1;
        dec_last_q   <= ((sample_cnt_q + 32'd1) == nb_q);
        dec_pair_q   <= {dec_b, dec_a};
        sample_cnt_q <= sample_cnt_q + 32'd1;
      end else if (sample_take) begin
        acc_a_q <= sum_a;
        acc_b_q <= sum_b;
        dcnt_q  <= dcnt_q + 1'b1;
      end
    end
  end

  assign burst_wrap = (size_q != 32'd0) && (burst_cnt_q == size_q - 32'd1);

  // Beat assembly: pair two decimated samples, pad the odd final one with zero.
  always_comb begin
    push_en   = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    if (dec_valid_q) begin
      if (have_low_q) begin
        push_en   = 1'b1;
        push_data = {dec_pair_q, low_q};
        push_last = dec_last_q || burst_wrap;
      end else if (dec_last_q) begin
        push_en   = 1'b1;
        push_data = {{PAIR_W{1'b0}}, dec_pair_q};
        push_last = 1'b1;
      end
    end
`ifdef NMR_PCK_TIMESTAMP_EN
    // Header goes out in the first RUN cycle, before any data can be ready.
    if ((state_q == ST_RUN) && hdr_pending_q) begin
      push_en   = 1'b1;
      push_data = {{(BEAT_W-64){1'b0}}, HDR_MAGIC, ts_q};
      push_last = burst_wrap;
    end
`endif
  end

  // Low-half holding register, burst beat index and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_q       <= '0;
      have_low_q  <= 1'b0;
      burst_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (dec_valid_q) begin
        if (have_low_q) begin
          have_low_q <= 1'b0;
        end else if (!dec_last_q) begin
          low_q      <= dec_pair_q;
          have_low_q <= 1'b1;
        end
      end
      if (push_en) begin
        burst_cnt_q <= burst_wrap ? 32'd0 : burst_cnt_q + 32'd1;
      end
      if (fifo_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef NMR_PCK_TIMESTAMP_EN
  // Free-running timestamp and one-shot header request on entering RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q          <= '0;
      hdr_pending_q <= 1'b0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if ((state_q == ST_IDLE) && (cfg_nb_of_sample != 32'd0)) begin
        hdr_pending_q <= 1'b1;
      end else if (state_q == ST_RUN) begin
        hdr_pending_q <= 1'b0;
      end
    end
  end
`endif

  nmr_pck_fifo #(
    .WIDTH (BEAT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_data ({push_last, push_data}),
    .pop       (m_axis_tready),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_out[BEAT_W-1:0];
  assign m_axis_tlast  = fifo_out[BEAT_W];
  assign done          = (state_q == ST_DONE);
  assign overflow      = overflow_q;
  assign sample_cnt    = sample_cnt_q;

endmodule

// File: doc/nmr_sample_packer.md
Name: nmr_sample_packer

Overview:
- Acquisition-side stage directly downstream of the NMR acquisition sequencer.
- Consumes the free-running dual-channel ADC sample stream while the sequencer holds the packer out of reset (ACQ window).
- Boxcar-decimates the samples, packs two decimated sample pairs per 64-bit beat, and emits AXI-Stream bursts to the DMA writer.
- Stops after exactly nb_of_sample decimated samples and flags done.

Parameters:
DATA_W, 16, bits per ADC channel sample (signed)
MAX_DECIM_LOG2, 8, largest supported log2 decimation factor
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset (driven from sequencer rst_pck inverted)
s_adc_tdata  in  2*DATA_W  [DATA_W-1:0]=ch A, upper=ch B, signed
s_adc_tvalid  in  1  sample strobe; no ready, source cannot stall
cfg_nb_of_sample  in  32  decimated samples to produce
cfg_size  in  32  beats per burst (tlast period); 0 = tlast only on final beat
cfg_decim_log2  in  4  decimation = 2^cfg_decim_log2, clamped to MAX_DECIM_LOG2
m_axis_tdata  out  4*DATA_W  low half = older sample pair
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  writer ready
m_axis_tlast  out  1  end of burst / end of acquisition
done  out  1  all samples emitted and FIFO drained
overflow  out  1  sticky, a beat was dropped on FIFO full
sample_cnt  out  32  decimated samples produced so far

Behaviour:
- Reset (sync, rst=1): all outputs 0, FIFO empty, counters 0, state IDLE; overrides everything incl. mid-burst (in-flight data discarded, tvalid drops next edge).
- Configuration latched in IDLE, the first cycle with rst=0; later cfg changes ignored until next reset.
- States: IDLE -> RUN (cfg_nb_of_sample!=0) or DONE (==0, no beats). RUN -> FLUSH when sample_cnt reaches nb_of_sample. FLUSH -> DONE when FIFO empty. DONE absorbing until reset.
- Decimation (RUN only, per channel): signed accumulator of width DATA_W+MAX_DECIM_LOG2 adds each valid sample; after 2^d samples output = acc >>> d (arithmetic, truncation toward -inf), cleared to 0 on same edge; d=0 passes samples through with 1-cycle latency.
- Packer: first decimated pair held in low half, second completes beat -> FIFO push same cycle. If nb_of_sample odd, final beat pushed with high half = 0.
- Input samples arriving in IDLE, FLUSH, DONE are ignored.
- tlast: beat index (from 0) mod cfg_size == cfg_size-1, or final beat; both -> single tlast.
- FIFO: AXI-S handshake on tvalid&tready; tdata/tlast stable while tvalid&!tready. Push when full: beat dropped, overflow set (sticky), sample_cnt still advances. Simultaneous push+pop when full is accepted (no drop).
- done = 1 in DONE; sample_cnt saturates at nb_of_sample.
- Latency s_adc_tvalid (completing beat, d=0) -> m_axis_tvalid: 2 cycles with FIFO empty.

Optional Feature:
NMR_PCK_TIMESTAMP_EN
- Defined: 32-bit cycle counter runs from reset release; on entering RUN one header beat {32'hA5A5_0001, timestamp} is pushed first; it counts toward cfg_size burst beat index but not toward sample_cnt.
- Undefined: no counter, no header; first beat is sample data.

Decomposition:
- Package nmr_pck_pkg: state enum (IDLE, RUN, FLUSH, DONE), header magic constant, accumulator width function.
- One sub-module: nmr_pck_fifo (sync FIFO, FIFO_DEPTH, full/empty, push-while-full-with-pop allowed).

Test Plan:
- d=0, nb=4, size=0, tready=1, samples A/B=1..4 -> 2 beats {2,2,1,1},{4,4,3,3} (16-bit fields hi->lo: B2,A2,B1,A1), tlast on beat 2, done, sample_cnt=4.
- d=2, nb=3, A=+5,+6,+7,+8 then -1,-2,-3,-4 then 0s -> outputs A=6,-3,0; beat2 high half 0; overflow=0.
- nb=8, size=2, tready=1 -> 4 beats, tlast on beats 2 and 4.
- tready=0 throughout, nb=20, FIFO_DEPTH=4 -> 4 beats held, overflow=1, sample_cnt=20, stays in FLUSH until tready raised, then DONE.
- rst pulsed mid-RUN after 3 beats -> tvalid=0, done=0, overflow=0 next cycle; new config latched, run completes normally.
- nb=0 -> DONE two cycles after reset release, no tvalid ever.
